// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the two-requester MMIO bus arbiter.
package mmio_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Read data returned to a requester when the peripheral never answers
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } arb_state_e;

  typedef enum logic {
    ID_M0 = 1'b0,
    ID_M1 = 1'b1
  } req_id_e;

  // Opposite requester id, used by the round-robin chooser
  function automatic req_id_e other_id(input req_id_e id);
    return (id == ID_M0) ? ID_M1 : ID_M0;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone request wins outright, a tie goes to
// the requester that was not granted last. Purely combinational.
module rr_pick2
  import mmio_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_id_i,
  output req_id_e    gnt_id_o,
  output logic       gnt_valid_o
);

  // Pick the winner from the request pair and the previous grant
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = ID_M0;
    case (req_i)
      2'b01:   gnt_id_o = ID_M0;
      2'b10:   gnt_id_o = ID_M1;
      2'b11:   gnt_id_o = other_id(last_id_i);
      default: gnt_id_o = ID_M0;
    endcase
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Arbitrates one MMIO register bus between two requesters. One transaction
// in flight at a time, round-robin on contention, read timeout with an error
// completion. Every output comes straight from a register.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_wr,
  input  logic              m0_rd,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_wr,
  input  logic              m1_rd,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic              bus_rd_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  req_id_e           gnt_id_q, gnt_id_d;
  req_id_e           last_id_q, last_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bus_wr_q, bus_wr_d;
  logic              bus_rd_q, bus_rd_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  logic [1:0] req;
  req_id_e    pick_id;
  logic       pick_valid;
  logic       pick_is_wr;

  // A requester whose ack is showing this cycle still holds its old request;
  // masking it keeps a completed read from being granted a second time.
  assign req[0] = (m0_wr | m0_rd) & ~ack_q[0];
  assign req[1] = (m1_wr | m1_rd) & ~ack_q[1];

  rr_pick2 u_pick (
    .req_i       (req),
    .last_id_i   (last_id_q),
    .gnt_id_o    (pick_id),
    .gnt_valid_o (pick_valid)
  );

  // wr wins over rd when both are raised together
  assign pick_is_wr = (pick_id == ID_M1) ? m1_wr : m0_wr;

  // Next-state and registered-output decode
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    last_id_d  = last_id_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bus_wr_d   = 1'b0;
    bus_rd_d   = 1'b0;
    ack_d      = 2'b00;
    err_d      = err_q;
    rdata_d[0] = rdata_q[0];
    rdata_d[1] = rdata_q[1];

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_id_d  = pick_id;
          last_id_d = pick_id;
          addr_d    = (pick_id == ID_M1) ? m1_addr  : m0_addr;
          wdata_d   = (pick_id == ID_M1) ? m1_wdata : m0_wdata;
          if (pick_is_wr) begin
            state_d        = WR;
            bus_wr_d       = 1'b1;
            ack_d[pick_id] = 1'b1;
            err_d[pick_id] = 1'b0;
          end else begin
            state_d  = RD;
            bus_rd_d = 1'b1;
          end
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        cnt_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus_rd_valid) begin
          rdata_d[gnt_id_q] = bus_rdata;
          err_d[gnt_id_q]   = 1'b0;
          ack_d[gnt_id_q]   = 1'b1;
          state_d           = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d[gnt_id_q] = ERR_DATA;
          err_d[gnt_id_q]   = 1'b1;
          ack_d[gnt_id_q]   = 1'b1;
          state_d           = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything so nothing is X
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_id_q   <= ID_M0;
      last_id_q  <= ID_M1;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bus_wr_q   <= 1'b0;
      bus_rd_q   <= 1'b0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      last_id_q  <= last_id_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bus_wr_q   <= bus_wr_d;
      bus_rd_q   <= bus_rd_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_wr    = bus_wr_q;
  assign bus_rd    = bus_rd_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter with a two-register PWM-style
// peripheral at FFFF_0000 / FFFF_0004 answering reads one cycle after bus_rd.
module tb_mmio_bus_arbiter;

  localparam int          T     = 16;
  localparam logic [31:0] A_REG = 32'hFFFF_0000;
  localparam logic [31:0] B_REG = 32'hFFFF_0004;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_wr = 1'b0, m0_rd = 1'b0, m1_wr = 1'b0, m1_rd = 1'b0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_wr, bus_rd, bus_rd_valid, busy;

  logic        per_vld = 1'b0;
  logic [31:0] per_rdata = '0;
  logic [31:0] regs [2];
  logic        mute = 1'b0;
  logic        stray = 1'b0;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  ack_exp_t q_ack0[$];
  ack_exp_t q_ack1[$];
  bus_exp_t q_bus[$];

  always #5 clk = ~clk;

  mmio_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_wr        (m0_wr),
    .m0_rd        (m0_rd),
    .m0_ack       (m0_ack),
    .m0_rdata     (m0_rdata),
    .m0_err       (m0_err),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_wr        (m1_wr),
    .m1_rd        (m1_rd),
    .m1_ack       (m1_ack),
    .m1_rdata     (m1_rdata),
    .m1_err       (m1_err),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_rd_valid (bus_rd_valid),
    .bus_rdata    (bus_rdata),
    .busy         (busy)
  );

  assign bus_rd_valid = per_vld | stray;
  assign bus_rdata    = per_rdata;

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Register peripheral: write on bus_wr, answer bus_rd one cycle later
  initial begin
    regs[0] = '0;
    regs[1] = '0;
  end
  always @(posedge clk) begin
    per_vld   <= bus_rd & ~mute;
    per_rdata <= regs[bus_addr[2]];
    if (bus_wr) regs[bus_addr[2]] <= bus_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ack(input int id, input logic [31:0] rdata, input logic err);
    ack_exp_t e;
    if ((id == 0 && q_ack0.size() == 0) || (id == 1 && q_ack1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_ack m%0d: got ack=1 expected ack=0 (cycle %0d)", id, cyc);
    end else begin
      e = (id == 0) ? q_ack0.pop_front() : q_ack1.pop_front();
      if (e.chk_rd) check($sformatf("rdata_m%0d", id), rdata, e.rdata);
      check($sformatf("err_m%0d", id), {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows an ack or a strobe
  always @(negedge clk) begin
    if (m0_ack && m1_ack) begin
      total++;
      bad++;
      $display("FAIL ack_onehot: got m0_ack=1 m1_ack=1 expected at most one (cycle %0d)", cyc);
    end
    if (m0_ack) chk_ack(0, m0_rdata, m0_err);
    if (m1_ack) chk_ack(1, m1_rdata, m1_err);
    if (bus_wr || bus_rd) begin
      if (q_bus.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got wr=%0b rd=%0b expected none (cycle %0d)", bus_wr, bus_rd, cyc);
      end else begin
        bus_exp_t b;
        b = q_bus.pop_front();
        check("bus_strobe", {30'd0, bus_wr, bus_rd}, {30'd0, b.wr, ~b.wr});
        check("bus_addr", bus_addr, b.addr);
        if (b.wr) check("bus_wdata", bus_wdata, b.wdata);
      end
    end
  end

  task automatic push_bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus_exp_t b;
    b.wr = wr;
    b.addr = addr;
    b.wdata = wdata;
    q_bus.push_back(b);
  endtask

  // Issue one transaction (caller is #1 after a posedge), wait for its ack,
  // optionally check latency, then drop the request the cycle after the ack.
  task automatic req_txn(input int id, input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input int exp_lat);
    ack_exp_t e;
    int start;
    bit got;
    e.chk_rd = rd & ~wr;
    e.rdata  = exp_rdata;
    e.err    = exp_err;
    if (id == 0) begin
      q_ack0.push_back(e);
      m0_addr = addr; m0_wdata = wdata; m0_wr = wr; m0_rd = rd;
    end else begin
      q_ack1.push_back(e);
      m1_addr = addr; m1_wdata = wdata; m1_wr = wr; m1_rd = rd;
    end
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((id == 0) ? m0_ack : m1_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_wait m%0d: got no ack expected ack within 100 cycles", id);
    end else if (exp_lat >= 0) begin
      check($sformatf("ack_latency_m%0d", id), cyc - start, exp_lat);
    end
    sync();
    if (id == 0) begin
      m0_wr = 1'b0; m0_rd = 1'b0;
    end else begin
      m1_wr = 1'b0; m1_rd = 1'b0;
    end
  endtask

  initial begin
    // 1. reset held with requests pending, then m0 wins the first grant
    m0_addr = A_REG; m0_wdata = 32'h11; m0_wr = 1'b1;
    m1_addr = B_REG; m1_wdata = 32'h22; m1_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ctrl", {25'd0, m0_ack, m1_ack, m0_err, m1_err, bus_wr, bus_rd, busy}, 32'd0);
      check("reset_bus_addr", bus_addr, 32'd0);
      check("reset_bus_wdata", bus_wdata, 32'd0);
      check("reset_rdata", m0_rdata | m1_rdata, 32'd0);
    end
    sync();
    rst = 1'b1;
    push_bus(1'b1, A_REG, 32'h11);
    push_bus(1'b1, B_REG, 32'h22);
    fork
      req_txn(0, 1'b1, 1'b0, A_REG, 32'h11, 32'h0, 1'b0, 1);
      req_txn(1, 1'b1, 1'b0, B_REG, 32'h22, 32'h0, 1'b0, -1);
    join

    // 2. m0 write then read back
    push_bus(1'b1, A_REG, 32'hAA);
    req_txn(0, 1'b1, 1'b0, A_REG, 32'h0000_00AA, 32'h0, 1'b0, 1);
    push_bus(1'b0, A_REG, 32'h0);
    req_txn(0, 1'b0, 1'b1, A_REG, 32'h0, 32'hAA, 1'b0, 3);

    // 3. contention: four writes each, grants alternate starting with m0
    sync(); rst = 1'b0; sync(); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_bus(1'b1, A_REG, 32'h10 + i);
      push_bus(1'b1, B_REG, 32'h20 + i);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) req_txn(0, 1'b1, 1'b0, A_REG, 32'h10 + i, 32'h0, 1'b0, -1);
      end
      begin
        for (int j = 0; j < 4; j++) req_txn(1, 1'b1, 1'b0, B_REG, 32'h20 + j, 32'h0, 1'b0, -1);
      end
    join
    push_bus(1'b0, A_REG, 32'h0);
    req_txn(0, 1'b0, 1'b1, A_REG, 32'h0, 32'h13, 1'b0, 3);
    push_bus(1'b0, B_REG, 32'h0);
    req_txn(1, 1'b0, 1'b1, B_REG, 32'h0, 32'h23, 1'b0, 3);

    // 4. silent peripheral -> timeout error, then m1 served normally
    mute = 1'b1;
    push_bus(1'b0, A_REG, 32'h0);
    req_txn(0, 1'b0, 1'b1, A_REG, 32'h0, 32'hDEAD_BEEF, 1'b1, T + 2);
    mute = 1'b0;
    push_bus(1'b0, B_REG, 32'h0);
    req_txn(1, 1'b0, 1'b1, B_REG, 32'h0, 32'h23, 1'b0, 3);

    // 5. reset inside RD_WAIT, then a stray read-valid
    mute = 1'b1;
    push_bus(1'b0, A_REG, 32'h0);
    m0_addr = A_REG; m0_rd = 1'b1;
    repeat (4) sync();
    check("rd_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0; m0_rd = 1'b0;
    sync(); sync();
    rst = 1'b1; mute = 1'b0; stray = 1'b1;
    sync();
    stray = 1'b0;
    repeat (4) sync();
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_m0_rdata", m0_rdata, 32'd0);
    check("stray_m1_rdata", m1_rdata, 32'd0);

    // 6. wr and rd together is a write
    push_bus(1'b1, B_REG, 32'h55);
    req_txn(1, 1'b1, 1'b1, B_REG, 32'h55, 32'h0, 1'b0, 1);
    push_bus(1'b0, B_REG, 32'h0);
    req_txn(1, 1'b0, 1'b1, B_REG, 32'h0, 32'h55, 1'b0, 3);

    repeat (3) sync();
    check("sb_drained", q_ack0.size() + q_ack1.size() + q_bus.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
